// File: rtl/nes_reader.sv
// Polls an NES controller: drives latch/pulse, samples active-low serial data, publishes active-high buttons.
// Latency: one frame every POLL_CYCLES cycles; results and valid strobe appear 16*HALF cycles after latch rises.
// Backpressure: none; valid is a one-cycle strobe, and buttons/pressed hold their values until the next frame.
module nes_reader #(
    parameter int HALF        = 300,
    parameter int POLL_CYCLES = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_n,
    output logic       latch,
    output logic       pulse,
    output logic [7:0] buttons,
    output logic [7:0] pressed,
    output logic       valid
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int HW = $clog2(2 * HALF);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PULSE_HI,
        PULSE_LO,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [PW-1:0]   poll_cnt;
    logic [HW-1:0]   half_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic [7:0]      shift_next;
    logic            sync1;
    logic            sync2;
    logic            frame_start;
    logic            last_latch;
    logic            last_half;
    logic            sample;

    assign frame_start = (poll_cnt == PW'(POLL_CYCLES - 1));
    assign last_latch  = (half_cnt == HW'(2 * HALF - 1));
    assign last_half   = (half_cnt == HW'(HALF - 1));

    // Two-flop synchronizer for the asynchronous serial line; resets to the released (idle) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= data_n;
            sync2 <= sync1;
        end
    end

    // Free-running frame timer; the wrap edge is the frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (frame_start) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // Next-state logic; sample marks the final cycle of LATCH and of each PULSE_LO phase.
    always_comb begin
        state_n    = state;
        sample     = 1'b0;
        shift_next = shift_reg;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_n = LATCH;
                end
            end
            LATCH: begin
                if (last_latch) begin
                    sample  = 1'b1;
                    state_n = PULSE_HI;
                end
            end
            PULSE_HI: begin
                if (last_half) begin
                    state_n = PULSE_LO;
                end
            end
            PULSE_LO: begin
                if (last_half) begin
                    sample  = 1'b1;
                    state_n = (bit_idx == 3'd7) ? DONE : PULSE_HI;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (sample) begin
            shift_next[bit_idx] = sync2;
        end
    end

    // State register and phase counter; the counter restarts whenever the phase changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            half_cnt <= '0;
        end else begin
            state    <= state_n;
            half_cnt <= (state_n != state) ? '0 : half_cnt + 1'b1;
        end
    end

    // Bit index and sample capture; index restarts at A on entry to LATCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            shift_reg <= shift_next;
            if (state == IDLE && state_n == LATCH) begin
                bit_idx <= '0;
            end else if (sample) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Registered outputs; buttons/pressed update on the edge entering DONE so they coincide with valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch   <= 1'b0;
            pulse   <= 1'b0;
            valid   <= 1'b0;
            buttons <= '0;
            pressed <= '0;
        end else begin
            latch <= (state_n == LATCH);
            pulse <= (state_n == PULSE_HI);
            valid <= (state_n == DONE);
            if (sample && bit_idx == 3'd7) begin
                buttons <= ~shift_next;
                pressed <= ~shift_next & ~buttons;
            end
        end
    end

endmodule

// File: tb/tb_nes_reader.sv
// Bench for nes_reader: controller model on latch/pulse, waveform and button-word reference model.
// Frame timing is predicted from HALF/POLL_CYCLES arithmetic; buttons/pressed from the pad pattern.
// Runs a fixed sequence of scenario tasks and prints one summary line.
module tb_nes_reader;

    localparam int H  = 4;
    localparam int P  = 80;
    localparam int FL = 16 * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_n;
    logic       latch;
    logic       pulse;
    logic [7:0] buttons;
    logic [7:0] pressed;
    logic       valid;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int last_v = -1;

    logic [7:0] pad = 8'h00;
    logic [7:0] exp_prev = 8'h00;
    int         idx = 0;
    logic       glitch_en = 1'b0;
    logic       rnd = 1'b0;
    logic       base_n;

    nes_reader #(.HALF(H), .POLL_CYCLES(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_n  (data_n),
        .latch   (latch),
        .pulse   (pulse),
        .buttons (buttons),
        .pressed (pressed),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Controller: parallel load while latch is high, advance one bit per pulse rising edge.
    always @(posedge latch or posedge pulse) begin
        if (latch) idx = 0;
        else idx = idx + 1;
    end

    always_comb base_n = (idx < 8) ? ~pad[idx[2:0]] : 1'b1;

    always @(negedge clk) rnd = 1'($urandom_range(0, 1));

    // Glitches only while pulse is high, well clear of every sample point.
    assign data_n = base_n ^ (glitch_en & pulse & rnd);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_prev = 8'h00;
        last_v = -1;
    endtask

    // Waits for latch, then walks one frame comparing against the arithmetic waveform.
    task automatic measure_frame(output int wait_n, output int wave_err, output int stray,
                                 output logic [7:0] b, output logic [7:0] p, output int vcyc);
        logic el, ep, ev;
        wait_n = 0; wave_err = 0; stray = 0; b = 8'h00; p = 8'h00; vcyc = -1;
        while (latch !== 1'b1 && wait_n < 3 * P) begin
            @(negedge clk);
            wait_n++;
            if (valid === 1'b1) stray++;
        end
        if (latch !== 1'b1) return;
        for (int r = 0; r <= FL + 1; r++) begin
            el = (r < 2 * H);
            ep = (r >= 2 * H) && (r < FL) && (((r / H) % 2) == 0);
            ev = (r == FL);
            if (latch !== el || pulse !== ep || valid !== ev) wave_err++;
            if (r == FL) begin
                b = buttons; p = pressed; vcyc = cyc;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        nvec++;
        if ({latch, pulse, valid, buttons, pressed} !== 19'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got l=%b p=%b v=%b b=%h pr=%h expected all zero",
                     latch, pulse, valid, buttons, pressed);
        end
    endtask

    task automatic test_idle();
        int w, we, st, vc;
        logic [7:0] b, p;
        pad = 8'h00;
        do_reset();
        measure_frame(w, we, st, b, p, vc);
        nvec++; if (w !== P) begin nerr++; $display("FAIL first_latch_delay: got %0d expected %0d", w, P); end
        nvec++; if (we !== 0) begin nerr++; $display("FAIL idle_waveform: got %0d bad cycles expected 0", we); end
        nvec++; if (st !== 0) begin nerr++; $display("FAIL idle_stray_valid: got %0d expected 0", st); end
        nvec++; if (b !== 8'h00) begin nerr++; $display("FAIL idle_buttons: got %h expected 00", b); end
        nvec++; if (p !== 8'h00) begin nerr++; $display("FAIL idle_pressed: got %h expected 00", p); end
        last_v = vc;
    endtask

    // One frame with the given pad; compares button word, pressed mask, waveform and spacing.
    task automatic test_frames(input string name, input logic [7:0] pat);
        int w, we, st, vc;
        logic [7:0] b, p, eb, epr;
        pad = pat;
        eb  = pat;
        epr = pat & ~exp_prev;
        measure_frame(w, we, st, b, p, vc);
        exp_prev = eb;
        nvec++; if (b !== eb) begin nerr++; $display("FAIL %s_buttons: got %h expected %h", name, b, eb); end
        nvec++; if (p !== epr) begin nerr++; $display("FAIL %s_pressed: got %h expected %h", name, p, epr); end
        nvec++; if (we !== 0 || st !== 0) begin nerr++; $display("FAIL %s_waveform: got %0d bad cycles, %0d stray valid, expected 0", name, we, st); end
        if (last_v >= 0) begin
            nvec++;
            if (vc - last_v !== P) begin nerr++; $display("FAIL %s_spacing: got %0d expected %0d", name, vc - last_v, P); end
        end
        last_v = vc;
    endtask

    task automatic test_a_start();
        test_frames("a_start_f1", 8'h09);
        test_frames("a_start_f2", 8'h09);
    endtask

    task automatic test_up_down();
        test_frames("up", 8'h10);
        test_frames("up_down", 8'h30);
    endtask

    task automatic test_walking_one();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            test_frames("walk", v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) test_frames("random", 8'($urandom));
    endtask

    task automatic test_reset_mid_frame();
        int w, we, st, vc;
        logic [7:0] b, p;
        test_frames("right_pre", 8'h80);
        w = 0;
        while (latch !== 1'b1 && w < 3 * P) begin @(negedge clk); w++; end
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        nvec++;
        if ({latch, pulse, valid, buttons, pressed} !== 19'd0) begin
            nerr++;
            $display("FAIL midreset_outputs: got l=%b p=%b v=%b b=%h pr=%h expected all zero",
                     latch, pulse, valid, buttons, pressed);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_prev = 8'h00;
        measure_frame(w, we, st, b, p, vc);
        nvec++; if (w !== P) begin nerr++; $display("FAIL midreset_latch_delay: got %0d expected %0d", w, P); end
        nvec++; if (st !== 0 || we !== 0) begin nerr++; $display("FAIL midreset_waveform: got %0d stray valid, %0d bad cycles, expected 0", st, we); end
        nvec++; if (b !== 8'h80) begin nerr++; $display("FAIL midreset_buttons: got %h expected 80", b); end
        nvec++; if (p !== 8'h80) begin nerr++; $display("FAIL midreset_pressed: got %h expected 80", p); end
        exp_prev = 8'h80;
        last_v = vc;
    endtask

    task automatic test_glitch();
        glitch_en = 1'b1;
        for (int i = 0; i < 5; i++) test_frames("glitch", 8'($urandom));
        glitch_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_a_start();
        test_up_down();
        test_walking_one();
        test_random();
        test_reset_mid_frame();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nes_reader.md
# nes_reader

Polling master for the NES controller serial port: generates the latch and clock-pulse waveform, samples the controller's active-low serial data line, and presents the eight button states as a parallel active-high word. Runs off the system clock; its `valid` strobe and `pressed` mask drive the offset counter's register/increase/decrease inputs in the NES-to-VGA path.

## Interface
- `HALF`, 300: cycles per half-bit (pulse high time = pulse low time = HALF; latch width = 2·HALF). Must be ≥ 3.
- `POLL_CYCLES`, 833333: cycles between frame starts. Must be ≥ 16·HALF + 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  reset, asynchronous, active-high.
- `data_n`  input  1  controller serial data, active-low (0 = pressed). Asynchronous to `clk`.
- `latch`  output  1  parallel-load strobe to controller, registered.
- `pulse`  output  1  shift clock to controller, registered.
- `buttons`  output  8  current button state, active-high. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- `pressed`  output  8  newly pressed mask for the latest frame (`buttons` rising edges).
- `valid`  output  1  one-cycle strobe: `buttons`/`pressed` just updated.

## Operation
- `data_n` passes through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
- Free-running `poll_cnt`, 0..POLL_CYCLES-1, wraps to 0. A frame starts on the edge where `poll_cnt` wraps from POLL_CYCLES-1 to 0.
- States: IDLE, LATCH, PULSE_HI, PULSE_LO, DONE. Half-bit counter counts within each phase; bit index 0..7.
- IDLE: `latch`=0, `pulse`=0. On frame start → LATCH.
- LATCH: `latch`=1 for 2·HALF cycles. Final cycle: sample bit 0 (A). → PULSE_HI, bit index 1.
- PULSE_HI: `pulse`=1 for HALF cycles → PULSE_LO.
- PULSE_LO: `pulse`=0 for HALF cycles. Final cycle: sample bit[index]. Index < 7 → increment, PULSE_HI; index = 7 → DONE.
- 7 pulses per frame (the trailing 8th pulse is not issued).
- DONE (one cycle): `buttons` ← ~shift_reg; `pressed` ← ~shift_reg & ~buttons_old; `valid`=1. → IDLE.
- `buttons` and `pressed` hold between frames; `pressed` refreshes only at DONE.
- Opposing directions (Up+Down, Left+Right) reported as sampled; no filtering.
- Disconnected controller (`data_n` floats/pulled high) → `buttons` = 0x00.

## Timing
- Relative to frame start (cycle 0 = first cycle `latch`=1):
  - `latch` high cycles 0..2H-1.
  - Pulse k (k=1..7) high cycles 2kH..2kH+H-1, low 2kH+H..2kH+2H-1.
  - Bit k sampled at the end of cycle 2(k+1)H-1.
  - `valid` high during cycle 16H only; `buttons`/`pressed` new values visible from cycle 16H.
- `latch` falls and first `pulse` rises on the same edge.
- First frame after reset release starts at edge POLL_CYCLES (cycle count from first edge after release).
- Frame-to-frame `valid` spacing exactly POLL_CYCLES cycles.
- Reset (any time, including mid-frame): immediately `latch`=0, `pulse`=0, `buttons`=0x00, `pressed`=0x00, `valid`=0, `poll_cnt`=0, state IDLE, synchronizer and partial samples cleared; the interrupted frame produces no `valid`.

## Test plan
(HALF=4, POLL_CYCLES=80 → 64-cycle frame; controller model shifts on `pulse` rising edge, loads while `latch`=1.)
- Reset then idle, no buttons (model drives 0xFF on data_n) → `latch` rises at cycle 80, 8 cycles wide; 7 pulses of 4/4; `valid` at relative cycle 64; `buttons`=0x00, `pressed`=0x00.
- Model presses A+Start → `buttons`=0x09, `pressed`=0x09 at first `valid`; next frame same input → `buttons`=0x09, `pressed`=0x00.
- Up held, then Down added next frame → frame 1 `buttons`=0x10/`pressed`=0x10; frame 2 `buttons`=0x30/`pressed`=0x20.
- Walking-one per frame through bits 0..7 → `buttons` = 0x01, 0x02 … 0x80 in order, confirming bit ordering and 7-pulse count.
- Assert reset at relative cycle 30 of a frame with Right held → `latch`/`pulse` drop immediately, no `valid` for that frame, `buttons`=0x00; next `valid` exactly 80+64 cycles after reset release with `buttons`=0x80.
- `data_n` toggling mid-half-bit away from sample points → no effect on sampled value; `valid` spacing stays 80 cycles across 5 frames.
